hazard_info_stage_reg: RTL
==========================

// Module: hazard_info_stage_reg
// PURPOSE
//  Parametrised pipeline register for hazard-tracking info (result type, source/dest
//  register numbers, Tnew countdown) between stages of the pipelined MIPS core.
//  Adds stall-hold, bubble insertion, exception flush, a valid bit, per-stage Tnew
//  decrement and a forward-ready flag, so one module serves the D/E, E/M and M/W boundaries.
// PARAMETERS
//  ADDR_W    5  width of one register-number field
//  N_SRC     2  number of source register fields carried (A1, A2, ...)
//  RES_W     2  width of result-type code (0 = no result)
//  TNEW_W    2  width of Tnew (cycles until the result is produced)
//  DEC_TNEW  1  1: decrement Tnew on load (saturating at 0); 0: pass Tnew through unchanged
//  HCNT_W    4  width of the consecutive-hold counter
// PORTS
//  clk            in   1               clock, rising edge
//  reset          in   1               synchronous, active-high
//  exc_flush      in   1               exception/eret flush: clear the stage
//  stall          in   1               hold the current contents
//  bubble         in   1               load an empty slot instead of the input
//  in_valid       in   1               input slot holds a real instruction
//  in_res         in   RES_W           result type of the incoming instruction
//  in_src         in   N_SRC*ADDR_W    packed source registers; field k = [k*ADDR_W +: ADDR_W]
//  in_dst         in   ADDR_W          destination register (A3)
//  in_tnew        in   TNEW_W          Tnew at the input side
//  out_valid      out  1               registered valid
//  out_res        out  RES_W           registered result type
//  out_src        out  N_SRC*ADDR_W    registered source registers
//  out_dst        out  ADDR_W          registered destination register
//  out_tnew       out  TNEW_W          registered Tnew
//  out_fwd_ready  out  1               out_valid & out_dst!=0 & out_res!=0 & out_tnew==0
//  hold_cnt       out  HCNT_W          consecutive stall cycles, saturating
// BEHAVIOUR
//  - All state updates on posedge clk. Every register output resets to 0; out_fwd_ready = 0.
//  - Per-cycle priority: reset > exc_flush > stall > bubble > load.
//  - reset or exc_flush: valid, res, src, dst, tnew <- 0; hold_cnt <- 0.
//  - stall (no reset/flush): all fields hold; Tnew is NOT decremented;
//    hold_cnt <- hold_cnt+1, saturating at 2^HCNT_W-1. A bubble during stall is ignored.
//  - bubble (no stall): all fields <- 0 (empty slot); hold_cnt <- 0.
//  - load: fields <- inputs, 1-cycle latency; hold_cnt <- 0.
//    Tnew on load: DEC_TNEW=1: in_tnew==0 ? 0 : in_tnew-1; DEC_TNEW=0: in_tnew.
//  - Normalisation on load: in_valid=0 loads all fields as 0. in_dst==0 forces stored
//    res=0 and tnew=0, so $0 is never a hazard source.
//  - out_fwd_ready is combinational from the registered outputs only; no input->output path.
//  - Reset or exc_flush asserted mid-stall clears the stage immediately, and hold_cnt restarts at 0.
//  - No internal FSM beyond the data registers and the saturating hold counter.
//    Contents are overwritten only by load, bubble, reset or flush.
// TESTING
//  1 reset=1 for 1 cycle -> all outputs 0, fwd_ready=0, hold_cnt=0.
//  2 load valid, res=1, src={5'd9,5'd8}, dst=5'd10, tnew=2, DEC_TNEW=1 -> next cycle
//    out_tnew=1, fwd_ready=0; reload with tnew=1 -> out_tnew=0, fwd_ready=1.
//  3 load then stall for 20 cycles (HCNT_W=4) -> fields constant, tnew unchanged,
//    hold_cnt reaches 15 and stays; first non-stall cycle -> hold_cnt=0.
//  4 stall=1 and bubble=1 together -> hold wins; stall=0, bubble=1 -> all fields 0, valid=0.
//  5 exc_flush=1 together with stall=1 and valid input -> next cycle all zero;
//    in_dst=0 with res=2, tnew=1 -> stored res=0, tnew=0, fwd_ready=0.

Source files
------------

// File: rtl/hazard_info_stage_reg.sv
// ----------------------------------------------------------------------------
// hazard_info_stage_reg
//
// Pipeline register for hazard-tracking information between stages of the
// pipelined MIPS core (D/E, E/M, M/W). One slot carries:
//   valid, result type, source register numbers, destination register and
//   Tnew (cycles until the result is produced).
// The slot can be held (stall), emptied (bubble), cleared (exception flush).
// Tnew can optionally be decremented on load. A forward-ready flag is derived
// from the registered contents.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high; clears the stage
//   exc_flush      in   exception/eret flush; clears the stage
//   stall          in   hold the current contents (wins over bubble)
//   bubble         in   load an empty slot instead of the input
//   in_valid       in   input slot holds a real instruction
//   in_res         in   result type of the incoming instruction (0 = none)
//   in_src         in   packed source registers, field k = [k*ADDR_W +: ADDR_W]
//   in_dst         in   destination register
//   in_tnew        in   Tnew at the input side
//   out_valid      out  registered valid
//   out_res        out  registered result type
//   out_src        out  registered source registers
//   out_dst        out  registered destination register
//   out_tnew       out  registered Tnew
//   out_fwd_ready  out  result is available for forwarding now
//   hold_cnt       out  consecutive stall cycles, saturating
// ----------------------------------------------------------------------------
module hazard_info_stage_reg #(
  parameter int ADDR_W   = 5,
  parameter int N_SRC    = 2,
  parameter int RES_W    = 2,
  parameter int TNEW_W   = 2,
  parameter int DEC_TNEW = 1,
  parameter int HCNT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    exc_flush,
  input  logic                    stall,
  input  logic                    bubble,
  input  logic                    in_valid,
  input  logic [RES_W-1:0]        in_res,
  input  logic [N_SRC*ADDR_W-1:0] in_src,
  input  logic [ADDR_W-1:0]       in_dst,
  input  logic [TNEW_W-1:0]       in_tnew,
  output logic                    out_valid,
  output logic [RES_W-1:0]        out_res,
  output logic [N_SRC*ADDR_W-1:0] out_src,
  output logic [ADDR_W-1:0]       out_dst,
  output logic [TNEW_W-1:0]       out_tnew,
  output logic                    out_fwd_ready,
  output logic [HCNT_W-1:0]       hold_cnt
);

  logic                    r_valid;
  logic [RES_W-1:0]        r_res;
  logic [N_SRC*ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0]       r_dst;
  logic [TNEW_W-1:0]       r_tnew;
  logic [HCNT_W-1:0]       r_hold_cnt;

  // Tnew as seen one stage further down the pipe.
  logic [TNEW_W-1:0] w_tnew_adj;

  generate
    if (DEC_TNEW != 0) begin : g_dec_tnew
      assign w_tnew_adj = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
    end else begin : g_pass_tnew
      assign w_tnew_adj = in_tnew;
    end
  endgenerate

  // Normalised load values: an invalid slot loads as all zeros, and a write
  // to $0 never produces a result, so it can never be a hazard source.
  logic                    w_ld_valid;
  logic [RES_W-1:0]        w_ld_res;
  logic [N_SRC*ADDR_W-1:0] w_ld_src;
  logic [ADDR_W-1:0]       w_ld_dst;
  logic [TNEW_W-1:0]       w_ld_tnew;
  logic                    w_dst_zero;

  assign w_dst_zero = (in_dst == '0);

  always_comb begin
    w_ld_valid = 1'b0;
    w_ld_res   = '0;
    w_ld_src   = '0;
    w_ld_dst   = '0;
    w_ld_tnew  = '0;
    if (in_valid) begin
      w_ld_valid = 1'b1;
      w_ld_src   = in_src;
      w_ld_dst   = in_dst;
      if (!w_dst_zero) begin
        w_ld_res  = in_res;
        w_ld_tnew = w_tnew_adj;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || exc_flush) begin
      r_valid    <= 1'b0;
      r_res      <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_tnew     <= '0;
      r_hold_cnt <= '0;
    end else if (stall) begin
      // Contents hold (Tnew included); only the hold counter advances.
      if (r_hold_cnt != '1) begin
        r_hold_cnt <= r_hold_cnt + HCNT_W'(1);
      end
    end else if (bubble) begin
      r_valid    <= 1'b0;
      r_res      <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_tnew     <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_valid    <= w_ld_valid;
      r_res      <= w_ld_res;
      r_src      <= w_ld_src;
      r_dst      <= w_ld_dst;
      r_tnew     <= w_ld_tnew;
      r_hold_cnt <= '0;
    end
  end

  assign out_valid     = r_valid;
  assign out_res       = r_res;
  assign out_src       = r_src;
  assign out_dst       = r_dst;
  assign out_tnew      = r_tnew;
  assign hold_cnt      = r_hold_cnt;
  // Derived from registered state only, so there is no input-to-output path.
  assign out_fwd_ready = r_valid && (r_dst != '0) && (r_res != '0) && (r_tnew == '0);

endmodule
